// File: rtl/mem_loader_pkg.sv
// Shared definitions for the byte-stream RAM loader: FSM state encodings,
// header size and the checksum value that marks a good frame.
package mem_loader_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ADDR_LO = 3'd1,
      CNT_HI  = 3'd2,
      CNT_LO  = 3'd3,
      DATA    = 3'd4,
      CSUM    = 3'd5
   } state_t;

   localparam int         HDR_BYTES = 4;
   localparam logic [7:0] CSUM_OK   = 8'h00;

   // Running frame checksum: plain modulo-256 byte sum.
   function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
      return acc + b;
   endfunction

endpackage

// File: rtl/mem_loader.sv
// Byte-stream loader: parses ADDR/CNT header, assembles big-endian words, writes them
// to consecutive RAM addresses and checks a trailing sum. MEM_LOADER_TIMEOUT_EN adds an inactivity timeout.
module mem_loader
   import mem_loader_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 16
`ifdef MEM_LOADER_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = 1_000_000
`endif
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [7:0]            in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  mem_we,
   output logic                  busy,
   output logic                  done,
   output logic                  error
);

   localparam int BYTES = DATA_WIDTH / 8;
   localparam int HDR_W = (HDR_BYTES - 1) * 8;

   state_t                  state;
   logic [HDR_W-1:0]        hdr;
   logic [ADDR_WIDTH-1:0]   addr;
   logic [15:0]             remaining;
   logic [DATA_WIDTH-1:0]   word;
   logic [2:0]              byte_idx;
   logic [7:0]              sum;

   logic                    accept;
   logic [7:0]              sum_next;
   logic [HDR_BYTES*8-1:0]  header;
   logic [DATA_WIDTH-1:0]   word_next;
   logic                    byte_last;
   logic                    timed_out;

   // header is the full 4-byte header once the CNT_LO byte is on the bus.
   assign accept    = in_valid && in_ready;
   assign sum_next  = csum_add(sum, in_data);
   assign header    = {hdr, in_data};
   assign word_next = DATA_WIDTH'({word, in_data});
   assign byte_last = (byte_idx == 3'(BYTES - 1));

`ifdef MEM_LOADER_TIMEOUT_EN
   logic [31:0] idle_cnt;

   always_ff @(posedge clk) begin
      if (reset || accept || state == IDLE)
         idle_cnt <= '0;
      else
         idle_cnt <= idle_cnt + 32'd1;
   end

   assign timed_out = (state != IDLE) && !accept && (idle_cnt == 32'(TIMEOUT_CYCLES));
`else
   assign timed_out = 1'b0;
`endif

   // Single FSM block; mem_we/in_ready/done default to their idle values every cycle
   // so a write strobe or done pulse lasts exactly one cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
         hdr       <= '0;
         addr      <= '0;
         remaining <= '0;
         word      <= '0;
         byte_idx  <= '0;
         sum       <= '0;
      end else begin
         mem_we   <= 1'b0;
         in_ready <= 1'b1;
         done     <= 1'b0;
         if (timed_out) begin
            state <= IDLE;
            busy  <= 1'b0;
            error <= 1'b1;
         end else if (accept) begin
            sum <= sum_next;
            hdr <= header[HDR_W-1:0];
            case (state)
               IDLE: begin
                  sum   <= in_data;
                  error <= 1'b0;
                  busy  <= 1'b1;
                  state <= ADDR_LO;
               end
               ADDR_LO: state <= CNT_HI;
               CNT_HI:  state <= CNT_LO;
               CNT_LO: begin
                  addr      <= ADDR_WIDTH'(header[31:16]);
                  remaining <= header[15:0];
                  byte_idx  <= '0;
                  state     <= (header[15:0] == 16'd0) ? CSUM : DATA;
               end
               DATA: begin
                  word <= word_next;
                  if (byte_last) begin
                     // The write cycle also blocks the next byte, giving BYTES+1 cycles per word.
                     byte_idx  <= '0;
                     mem_we    <= 1'b1;
                     in_ready  <= 1'b0;
                     mem_addr  <= addr;
                     mem_wdata <= word_next;
                     addr      <= addr + 1'b1;
                     remaining <= remaining - 16'd1;
                     if (remaining == 16'd1)
                        state <= CSUM;
                  end else begin
                     byte_idx <= byte_idx + 3'd1;
                  end
               end
               CSUM: begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  if (sum_next == CSUM_OK)
                     done  <= 1'b1;
                  else
                     error <= 1'b1;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
